// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one FIFO: a winner holds the port (burst lock)
// until it marks last, withdraws valid, or reaches MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [ID_WIDTH-1:0]           fifo_id_o,
  output logic                          fifo_wr_valid_o,
  input  logic                          fifo_wr_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_CAP = CNT_WIDTH'(MAX_BURST - 1);

  logic [0:0]           state;
  logic [ID_WIDTH-1:0]  owner;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  winner;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 locked;
  logic                 owner_valid;
  logic                 beat;
  logic                 release_lock;

  // Index base+off folded back into 0..NUM_REQ-1 (off < NUM_REQ).
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // Scanning from the far end down means the closest valid requester to rr_ptr
  // is written last and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_valid_i[wrap_add(rr_ptr, off)]) winner = wrap_add(rr_ptr, off);
    end
  end

  // Reset blanks the port in the same cycle so a burst cut by reset pops nothing.
  assign locked       = (state == LOCK) && !rst;
  assign owner_valid  = req_valid_i[owner];
  assign beat         = locked && owner_valid && fifo_wr_ready_i;
  assign release_lock = locked &&
                        (!owner_valid ||
                         (beat && (req_last_i[owner] || beat_cnt == CNT_CAP)));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (|req_valid_i) begin
        state    <= LOCK;
        owner    <= winner;
        beat_cnt <= '0;
      end
    end else begin
      if (release_lock) begin
        state    <= IDLE;
        rr_ptr   <= (owner == LAST_ID) ? '0 : owner + ID_WIDTH'(1);
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    req_ready_o     = '0;
    grant_o         = '0;
    fifo_wr_valid_o = 1'b0;
    fifo_data_o     = '0;
    fifo_id_o       = '0;
    if (locked) begin
      req_ready_o[owner] = fifo_wr_ready_i;
      grant_o[owner]     = 1'b1;
      fifo_wr_valid_o    = owner_valid;
      fifo_data_o        = req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      fifo_id_o          = owner;
    end
  end

  assign busy_o = locked;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and random traffic compared against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] fifo_data;
  logic [1:0]    fifo_id;
  logic          fifo_wr_valid;
  logic          fifo_wr_ready;
  logic [N-1:0]  grant;
  logic          busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .fifo_data_o     (fifo_data),
    .fifo_id_o       (fifo_id),
    .fifo_wr_valid_o (fifo_wr_valid),
    .fifo_wr_ready_i (fifo_wr_ready),
    .grant_o         (grant),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Producers: each emits a sequence number that advances when its beat is taken.
  int seq [N];

  function automatic logic [DW-1:0] pdata(input int i);
    return 32'hA000_0000 | (32'(i) << 16) | (32'(seq[i]) & 32'h0000_FFFF);
  endfunction

  // Reference model: who holds the port, where the next search starts, beats so far.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_beats;

  task automatic model_step();
    bit beat;
    bit found;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_locked) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found   = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_locked = 1;
        m_beats  = 0;
      end
    end else begin
      beat = req_valid[m_owner] && fifo_wr_ready;
      if (beat) m_beats++;
      if (!req_valid[m_owner] || (beat && (req_last[m_owner] || m_beats == MB))) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % N;
      end
    end
  endtask

  // Values sampled mid-cycle, plus a log of grants and beats per grant.
  logic [N-1:0]  s_grant, s_ready, prev_grant;
  logic          s_wv, s_busy;
  logic [DW-1:0] s_data;
  logic [1:0]    s_id;
  int grant_ids [$];
  int grant_beats [$];

  function automatic int log_id(input int k);
    return (k < grant_ids.size()) ? grant_ids[k] : -1;
  endfunction

  function automatic int log_beats(input int k);
    return (k < grant_beats.size()) ? grant_beats[k] : -1;
  endfunction

  task automatic clear_log();
    grant_ids.delete();
    grant_beats.delete();
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are
  // checked on the falling edge; the model advances on the next rising edge.
  task automatic cycle();
    logic [N-1:0]  e_grant, e_ready;
    logic          e_wv, e_busy;
    logic [DW-1:0] e_data;
    logic [1:0]    e_id;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata(i);
    @(negedge clk);
    s_grant = grant; s_ready = req_ready; s_wv = fifo_wr_valid;
    s_data = fifo_data; s_id = fifo_id; s_busy = busy;
    e_grant = '0; e_ready = '0; e_wv = 0; e_busy = 0; e_data = '0; e_id = '0;
    if (!rst && m_locked) begin
      e_grant = 4'b0001 << m_owner;
      e_ready = fifo_wr_ready ? e_grant : 4'b0000;
      e_wv    = req_valid[m_owner];
      e_data  = req_data[m_owner*DW +: DW];
      e_id    = 2'(m_owner);
      e_busy  = 1;
    end
    check("model_grant", s_grant, e_grant);
    check("model_ready", s_ready, e_ready);
    check("model_wr_valid", s_wv, e_wv);
    check("model_data", s_data, e_data);
    check("model_id", s_id, e_id);
    check("model_busy", s_busy, e_busy);
    if (s_grant != 0 && prev_grant == 0) begin
      grant_ids.push_back(int'(s_id));
      grant_beats.push_back(0);
    end
    if (s_wv && fifo_wr_ready && grant_beats.size() > 0)
      grant_beats[grant_beats.size()-1]++;
    prev_grant = s_grant;
    @(posedge clk);
    for (int i = 0; i < N; i++) if (s_ready[i] && req_valid[i]) seq[i]++;
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; req_last = '0; fifo_wr_ready = 1;
    cycle();
    cycle();
    rst = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    clear_log();
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          rdy;
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_ready;
    logic          e_wv;
    logic [1:0]    e_id;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    rst = 1; req_valid = '0; req_last = '0; fifo_wr_ready = 1; req_data = '0;
    prev_grant = '0;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset with every requester valid, then one-beat bursts rotating 0,1,2,3,0.
    vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 32'hA000_0000};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 32'hA001_0000};
    vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 4'h4, 1'b1, 2'd2, 32'hA002_0000};
    vecs[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b1, 2'd3, 32'hA003_0000};
    vecs[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 32'hA000_0001};

    @(posedge clk);
    #1;

    for (int r = 0; r < 12; r++) begin
      rst = vecs[r].rst; req_valid = vecs[r].valid;
      req_last = vecs[r].last; fifo_wr_ready = vecs[r].rdy;
      cycle();
      check("tbl_grant", s_grant, vecs[r].e_grant);
      check("tbl_ready", s_ready, vecs[r].e_ready);
      check("tbl_wr_valid", s_wv, vecs[r].e_wv);
      check("tbl_id", s_id, vecs[r].e_id);
      check("tbl_data", s_data, vecs[r].e_data);
    end

    // Burst cap: req0 never marks last, req1 waiting.
    do_reset();
    req_valid = 4'b0011; req_last = '0; fifo_wr_ready = 1;
    repeat (30) cycle();
    check("cap_first_owner", log_id(0), 0);
    check("cap_first_beats", log_beats(0), MB);
    check("cap_second_owner", log_id(1), 1);
    check("cap_second_beats", log_beats(1), MB);
    check("cap_third_owner", log_id(2), 0);

    // Backpressure mid-burst: five stalled cycles after three beats.
    do_reset();
    req_valid = 4'b0001; req_last = '0; fifo_wr_ready = 1;
    repeat (4) cycle();
    fifo_wr_ready = 0;
    repeat (5) begin
      cycle();
      check("stall_data", s_data, 32'hA000_0003);
      check("stall_busy", s_busy, 1);
      check("stall_ready", s_ready, 4'h0);
    end
    fifo_wr_ready = 1;
    repeat (5) cycle();
    cycle();
    check("stall_release_busy", s_busy, 0);
    check("stall_burst_beats", log_beats(0), MB);

    // Owner 2 withdraws after three beats; req3 must beat req0.
    do_reset();
    req_valid = 4'b0100; req_last = '0; fifo_wr_ready = 1;
    repeat (4) cycle();
    req_valid = 4'b1001;
    cycle();
    check("wd_valid_low", s_wv, 0);
    check("wd_still_owner", s_grant, 4'h4);
    cycle();
    check("wd_idle", s_grant, 4'h0);
    cycle();
    check("wd_next_owner", s_id, 2'd3);
    check("wd_next_grant", s_grant, 4'h8);
    check("wd_beats", log_beats(0), 3);

    // Reset while owner 1 is mid-burst.
    do_reset();
    req_valid = 4'b0010; req_last = '0; fifo_wr_ready = 1;
    repeat (3) cycle();
    rst = 1; req_valid = 4'b1111;
    cycle();
    check("rst_mid_grant", s_grant, 4'h0);
    check("rst_mid_ready", s_ready, 4'h0);
    rst = 0;
    cycle();
    check("rst_after_grant", s_grant, 4'h0);
    cycle();
    check("rst_first_winner", s_grant, 4'h1);
    check("rst_no_pop", seq[1], 2);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 5) == 0);
      end
      fifo_wr_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
